// File: rtl/pe_ins_issue.sv
// -----------------------------------------------------------------------------
// pe_ins_issue -- instruction issuer on the initiator side of the PE-array
// instruction port.
//
// Accepts one task descriptor at a time from the layer controller. Each task
// has a target mask: one PE, or a 4-PE group. A per-PE busy scoreboard holds
// the instruction back until every target PE is idle. It then presents the
// instruction on ins/ins_valid and waits for ins_ready. Per-PE done pulses
// clear scoreboard bits. Out-of-range targets and done pulses on idle PEs
// raise a sticky error flag.
//
// Optional feature macro: PE_INS_ISSUE_PERF_EN
//   defined   : stall_cnt / issue_cnt are live saturating performance counters
//   undefined : stall_cnt / issue_cnt are tied to 0 (ports remain)
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   layer_type        bit 0: 1 = single-PE addressing, 0 = 4-PE group addressing
//   task_valid/ready  descriptor handshake from the layer controller
//   task_*            descriptor fields (pe_id, idx_cnt, trip_cnt, pad_code,
//                     is_new, cut_y)
//   ins, ins_valid    instruction word and valid to the PE array
//   ins_ready         PE array accepts the instruction
//   done              per-PE completion pulses
//   busy              scoreboard, 1 = PE executing a task
//   all_idle          no task pending and no PE busy
//   err, err_clr      sticky protocol error and its synchronous clear
//   stall_cnt         cycles pending with ins_valid low
//   issue_cnt         instructions issued
// -----------------------------------------------------------------------------

package INS_CONST;
  localparam int INST_W = 64;
endpackage

module pe_ins_issue #(
  parameter int PE_NUM = 32,
  parameter int INST_W = INS_CONST::INST_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        layer_type,
  input  logic              task_valid,
  output logic              task_ready,
  input  logic [5:0]        task_pe_id,
  input  logic [7:0]        task_idx_cnt,
  input  logic [7:0]        task_trip_cnt,
  input  logic [3:0]        task_pad_code,
  input  logic              task_is_new,
  input  logic              task_cut_y,
  output logic [INST_W-1:0] ins,
  output logic              ins_valid,
  input  logic              ins_ready,
  input  logic [PE_NUM-1:0] done,
  output logic [PE_NUM-1:0] busy,
  output logic              all_idle,
  output logic              err,
  input  logic              err_clr,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       issue_cnt
);

  localparam logic [0:0]  ST_IDLE = 1'b0;
  localparam logic [0:0]  ST_PEND = 1'b1;

  localparam logic [31:0] LIM_SINGLE = PE_NUM;
  localparam logic [31:0] LIM_GROUP  = PE_NUM / 4;

  // Instruction word packing; every bit outside the named fields is zero.
  function automatic logic [INST_W-1:0] build_ins(
    input logic [5:0] pe_id,
    input logic [7:0] idx_cnt,
    input logic [7:0] trip_cnt,
    input logic [3:0] pad_code,
    input logic       is_new,
    input logic       cut_y
  );
    logic [INST_W-1:0] w;
    w          = '0;
    w[39:32]   = idx_cnt;
    w[47:40]   = trip_cnt;
    w[51:48]   = pad_code;
    w[57:52]   = pe_id;
    w[58]      = is_new;
    w[59]      = cut_y;
    return w;
  endfunction

  logic [0:0]        state_r;
  logic [0:0]        state_nxt_s;
  logic [INST_W-1:0] ins_r;
  logic [PE_NUM-1:0] mask_r;
  logic [PE_NUM-1:0] busy_r;
  logic [PE_NUM-1:0] busy_nxt_s;
  logic              err_r;

  logic              single_s;
  logic [7:0]        grp_shift_s;
  logic [PE_NUM-1:0] mask_s;
  logic              range_err_s;
  logic              accept_s;
  logic              drop_s;
  logic              ins_valid_s;
  logic              hs_s;
  logic              done_err_s;
  logic              unused_s;

  // Layer-type bits above bit 0 carry no meaning for the issuer.
  assign unused_s = &{1'b0, layer_type[3:1]};

  // Target mask and range check from the descriptor on the task port.
  always_comb begin
    single_s    = layer_type[0];
    grp_shift_s = {task_pe_id, 2'b00};
    if (single_s) begin
      mask_s      = {{(PE_NUM-1){1'b0}}, 1'b1} << task_pe_id;
      range_err_s = ({26'd0, task_pe_id} >= LIM_SINGLE);
    end else begin
      mask_s      = {{(PE_NUM-4){1'b0}}, 4'hF} << grp_shift_s;
      range_err_s = ({26'd0, task_pe_id} >= LIM_GROUP);
    end
  end

  // Handshake qualifiers. ins_valid only depends on registered state and busy,
  // and busy can only lose bits while pending, so once high it holds.
  always_comb begin
    accept_s    = (state_r == ST_IDLE) && task_valid;
    drop_s      = accept_s && range_err_s;
    ins_valid_s = (state_r == ST_PEND) && ((mask_r & busy_r) == '0);
    hs_s        = ins_valid_s && ins_ready;
    done_err_s  = |(done & ~busy_r);
  end

  // Scoreboard next value: done clears first, then the issued mask is set.
  always_comb begin
    if (hs_s) begin
      busy_nxt_s = (busy_r & ~done) | mask_r;
    end else begin
      busy_nxt_s = busy_r & ~done;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && !range_err_s) begin
          state_nxt_s = ST_PEND;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_PEND: begin
        if (hs_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_PEND;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State and scoreboard registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      busy_r  <= '0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= busy_nxt_s;
    end
  end

  // Descriptor latch; only in-range tasks overwrite the held instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ins_r  <= '0;
      mask_r <= '0;
    end else if (accept_s && !range_err_s) begin
      ins_r  <= build_ins(task_pe_id, task_idx_cnt, task_trip_cnt,
                          task_pad_code, task_is_new, task_cut_y);
      mask_r <= mask_s;
    end
  end

  // Sticky error; a new error event wins over a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else if (drop_s || done_err_s) begin
      err_r <= 1'b1;
    end else if (err_clr) begin
      err_r <= 1'b0;
    end
  end

`ifdef PE_INS_ISSUE_PERF_EN
  logic [31:0] stall_cnt_r;
  logic [31:0] issue_cnt_r;

  // Saturating stall counter: pending cycles blocked by the scoreboard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= 32'd0;
    end else if ((state_r == ST_PEND) && !ins_valid_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end
  end

  // Saturating issue counter: one count per instruction handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt_r <= 32'd0;
    end else if (hs_s && (issue_cnt_r != 32'hFFFF_FFFF)) begin
      issue_cnt_r <= issue_cnt_r + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_r;
  assign issue_cnt = issue_cnt_r;
`else
  assign stall_cnt = 32'd0;
  assign issue_cnt = 32'd0;
`endif

  assign task_ready = (state_r == ST_IDLE);
  assign ins        = ins_r;
  assign ins_valid  = ins_valid_s;
  assign busy       = busy_r;
  assign all_idle   = (state_r == ST_IDLE) && (busy_r == '0);
  assign err        = err_r;

endmodule

// File: tb/tb_pe_ins_issue.sv
// Directed bench for pe_ins_issue: a vector table of single tasks followed by
// hand-written sequences for stalls, back-pressure, error and async reset.
module tb_pe_ins_issue;

  localparam int PE_NUM = 32;

  logic        clk;
  logic        rst_n;
  logic [3:0]  layer_type;
  logic        task_valid;
  logic        task_ready;
  logic [5:0]  task_pe_id;
  logic [7:0]  task_idx_cnt;
  logic [7:0]  task_trip_cnt;
  logic [3:0]  task_pad_code;
  logic        task_is_new;
  logic        task_cut_y;
  logic [63:0] ins;
  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] done;
  logic [31:0] busy;
  logic        all_idle;
  logic        err;
  logic        err_clr;
  logic [31:0] stall_cnt;
  logic [31:0] issue_cnt;

  int n_total;
  int n_pass;

  pe_ins_issue #(.PE_NUM(PE_NUM), .INST_W(64)) dut (
    .clk(clk), .rst_n(rst_n), .layer_type(layer_type),
    .task_valid(task_valid), .task_ready(task_ready),
    .task_pe_id(task_pe_id), .task_idx_cnt(task_idx_cnt),
    .task_trip_cnt(task_trip_cnt), .task_pad_code(task_pad_code),
    .task_is_new(task_is_new), .task_cut_y(task_cut_y),
    .ins(ins), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .done(done), .busy(busy), .all_idle(all_idle),
    .err(err), .err_clr(err_clr),
    .stall_cnt(stall_cnt), .issue_cnt(issue_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  lt;
    logic [5:0]  pe;
    logic [7:0]  idx;
    logic [7:0]  trip;
    logic [3:0]  pad;
    logic        is_new;
    logic        cut_y;
    logic [27:0] exp_hi;    // expected ins[59:32]
    logic [31:0] exp_busy;  // expected busy after the handshake
    logic        exp_err;   // task is out of range and must be dropped
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_task(input logic [3:0] lt, input logic [5:0] pe, input logic [7:0] idx,
                          input logic [7:0] trip, input logic [3:0] pad,
                          input logic is_new, input logic cut_y);
    layer_type    = lt;
    task_pe_id    = pe;
    task_idx_cnt  = idx;
    task_trip_cnt = trip;
    task_pad_code = pad;
    task_is_new   = is_new;
    task_cut_y    = cut_y;
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    step();
  endtask

  // Present a descriptor for one cycle.
  task automatic push(input logic [3:0] lt, input logic [5:0] pe);
    set_task(lt, pe, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0);
    task_valid = 1'b1;
    step();
    task_valid = 1'b0;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst_n = 1'b1; task_valid = 1'b0; ins_ready = 1'b1; done = 32'd0; err_clr = 1'b0;
    set_task(4'h0, 6'd0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0);

    //          lt    pe     idx    trip   pad   new   cut   exp_hi        exp_busy        err
    vecs[0] = '{4'h1, 6'd5,  8'h12, 8'h34, 4'hA, 1'b1, 1'b0, 28'h45A3412, 32'h0000_0020, 1'b0};
    vecs[1] = '{4'h0, 6'd2,  8'h01, 8'h02, 4'h3, 1'b0, 1'b1, 28'h8230201, 32'h0000_0F00, 1'b0};
    vecs[2] = '{4'h3, 6'd31, 8'hFF, 8'h00, 4'hF, 1'b1, 1'b1, 28'hDFF00FF, 32'h8000_0000, 1'b0};
    vecs[3] = '{4'h2, 6'd7,  8'h5A, 8'hA5, 4'h0, 1'b0, 1'b0, 28'h070A55A, 32'hF000_0000, 1'b0};
    vecs[4] = '{4'h1, 6'd40, 8'h11, 8'h22, 4'h3, 1'b0, 1'b0, 28'h0000000, 32'h0000_0000, 1'b1};
    vecs[5] = '{4'h0, 6'd8,  8'h11, 8'h22, 4'h3, 1'b0, 1'b0, 28'h0000000, 32'h0000_0000, 1'b1};
    vecs[6] = '{4'h1, 6'd0,  8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 28'h0000000, 32'h0000_0001, 1'b0};

    // Reset state
    do_reset();
    chk("rst_task_ready", 64'(task_ready), 64'd1);
    chk("rst_ins_valid",  64'(ins_valid),  64'd0);
    chk("rst_all_idle",   64'(all_idle),   64'd1);
    chk("rst_busy",       64'(busy),       64'd0);
    chk("rst_err",        64'(err),        64'd0);
    chk("rst_ins",        ins,             64'd0);
    chk("rst_stall_cnt",  64'(stall_cnt),  64'd0);
    chk("rst_issue_cnt",  64'(issue_cnt),  64'd0);

    // Table-driven single tasks
    for (int i = 0; i < 7; i++) begin
      set_task(vecs[i].lt, vecs[i].pe, vecs[i].idx, vecs[i].trip, vecs[i].pad,
               vecs[i].is_new, vecs[i].cut_y);
      ins_ready  = 1'b1;
      task_valid = 1'b1;
      step();
      task_valid = 1'b0;
      if (vecs[i].exp_err) begin
        chk($sformatf("v%0d_drop_err", i),        64'(err),        64'd1);
        chk($sformatf("v%0d_drop_ins_valid", i),  64'(ins_valid),  64'd0);
        chk($sformatf("v%0d_drop_task_ready", i), 64'(task_ready), 64'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk($sformatf("v%0d_err_clr", i), 64'(err), 64'd0);
      end else begin
        chk($sformatf("v%0d_ins_valid", i), 64'(ins_valid), 64'd1);
        chk($sformatf("v%0d_ins", i), ins, {4'h0, vecs[i].exp_hi, 32'h0});
        step();
        chk($sformatf("v%0d_busy", i),       64'(busy),       64'(vecs[i].exp_busy));
        chk($sformatf("v%0d_ins_valid_lo", i), 64'(ins_valid), 64'd0);
        chk($sformatf("v%0d_all_idle_lo", i),  64'(all_idle),  64'd0);
        done = vecs[i].exp_busy;
        step();
        done = 32'd0;
        chk($sformatf("v%0d_busy_clr", i), 64'(busy),     64'd0);
        chk($sformatf("v%0d_all_idle", i), 64'(all_idle), 64'd1);
        chk($sformatf("v%0d_no_err", i),   64'(err),      64'd0);
      end
    end

    // Group stall: second task to group 2 waits for all of done[11:8]
    do_reset();
    ins_ready = 1'b1;
    push(4'h0, 6'd2);
    step();
    chk("grp_busy", 64'(busy), 64'h0F00);
    push(4'h0, 6'd2);
    chk("grp_stall0", 64'(ins_valid), 64'd0);
    for (int b = 8; b < 12; b++) begin
      done = 32'd1 << b;
      step();
      done = 32'd0;
      chk($sformatf("grp_after_done%0d", b), 64'(ins_valid), (b == 11) ? 64'd1 : 64'd0);
    end
    step();
    chk("grp_busy2", 64'(busy), 64'h0F00);
`ifdef PE_INS_ISSUE_PERF_EN
    chk("grp_stall_cnt", 64'(stall_cnt), 64'd4);
    chk("grp_issue_cnt", 64'(issue_cnt), 64'd2);
`else
    chk("grp_stall_cnt", 64'(stall_cnt), 64'd0);
    chk("grp_issue_cnt", 64'(issue_cnt), 64'd0);
`endif
    done = 32'h0F00;
    step();
    done = 32'd0;
    chk("grp_idle", 64'(all_idle), 64'd1);

    // Back-pressure: ins_ready low for 3 cycles in PEND
    do_reset();
    ins_ready = 1'b0;
    set_task(4'h1, 6'd1, 8'h10, 8'h20, 4'h1, 1'b0, 1'b0);
    task_valid = 1'b1;
    step();
    task_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("bp%0d_valid", c), 64'(ins_valid), 64'd1);
      chk($sformatf("bp%0d_ins", c),   ins,            64'h0112_0100_0000_0000 >> 4);
      chk($sformatf("bp%0d_busy", c),  64'(busy),      64'd0);
      if (c < 2) step();
    end
    ins_ready = 1'b1;
    step();
    chk("bp_busy", 64'(busy), 64'h2);
    chk("bp_task_ready", 64'(task_ready), 64'd1);
`ifdef PE_INS_ISSUE_PERF_EN
    chk("bp_stall_cnt", 64'(stall_cnt), 64'd0);
    chk("bp_issue_cnt", 64'(issue_cnt), 64'd1);
`endif

    // Spurious done with coincident err_clr: set wins
    do_reset();
    done = 32'h8; err_clr = 1'b1;
    step();
    done = 32'd0; err_clr = 1'b0;
    chk("spur_err",  64'(err),  64'd1);
    chk("spur_busy", 64'(busy), 64'd0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("spur_err_clr", 64'(err), 64'd0);

    // Asynchronous reset mid-PEND with busy = 0x3
    do_reset();
    ins_ready = 1'b1;
    push(4'h1, 6'd0);
    step();
    push(4'h1, 6'd1);
    step();
    chk("ar_busy", 64'(busy), 64'h3);
    done = 32'h20;
    step();
    done = 32'd0;
    ins_ready = 1'b0;
    push(4'h1, 6'd2);
    chk("ar_pend_valid", 64'(ins_valid), 64'd1);
    chk("ar_pre_err",    64'(err),       64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_busy_clr",  64'(busy),      64'd0);
    chk("ar_valid_clr", 64'(ins_valid), 64'd0);
    chk("ar_err_clr",   64'(err),       64'd0);
    #1;
    rst_n = 1'b1;
    ins_ready = 1'b1;
    step();
    chk("ar_task_ready", 64'(task_ready), 64'd1);
    chk("ar_all_idle",   64'(all_idle),   64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
